// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, data word and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_prio.sv
// Data-first grant pick with an anti-starvation counter that forces an instruction
// grant after STARVE_MAX consecutive data grants taken while a fetch was pending.
module arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic ireq,
  input  logic dreq,
  output logic pick_i,
  output logic pick_d
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  always_comb begin
    pick_d = dreq && ((starve_cnt < SMAX) || !ireq);
    pick_i = ireq && !pick_d;
  end

  // Only decisions taken in IDLE count; a data pick implies starve_cnt < SMAX when ireq is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (pick_d && ireq) begin
        starve_cnt <= starve_cnt + 1'b1;
      end else if (pick_i || !ireq) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; hits are combinational
// in the ACCESS cycle, one IDLE cycle separates grants, a watchdog bounds each grant.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  ramstate_t ramstate,
  input  word_t     ramload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     iload,
  output word_t     dload,
  output logic      timeout_err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

  arb_state_t    state, next_state;
  logic [WW-1:0] wait_cnt;
  logic          wait_inc, timeout_hit, req, idle, dreq, pick_i, pick_d;

  assign idle = (state == IDLE);
  assign dreq = dREN | dWEN;

  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (CLK),
    .rst    (RST),
    .idle   (idle),
    .ireq   (iREN),
    .dreq   (dreq),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Everything stays at zero while RST is high so a grant cut by reset issues no hit.
  always_comb begin
    next_state  = state;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    ihit        = 1'b0;
    dhit        = 1'b0;
    iload       = '0;
    dload       = '0;
    wait_inc    = 1'b0;
    timeout_hit = 1'b0;
    req         = (state == GRANT_I) ? iREN : dreq;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (pick_d)      next_state = GRANT_D;
          else if (pick_i) next_state = GRANT_I;
        end
        GRANT_I, GRANT_D: begin
          if (!req) begin
            next_state = IDLE;
          end else begin
            if (state == GRANT_I) begin
              ramREN  = 1'b1;
              ramaddr = iaddr;
            end else begin
              ramaddr  = daddr;
              ramstore = dstore;
              ramWEN   = dWEN;
              ramREN   = dREN & ~dWEN;
            end
            if (wait_cnt == WAIT_MAX) begin
              next_state  = IDLE;
              timeout_hit = 1'b1;
            end else if (ramstate == ACCESS) begin
              next_state = IDLE;
              if (state == GRANT_I) begin
                ihit  = 1'b1;
                iload = ramload;
              end else begin
                dhit  = 1'b1;
                dload = ramload;
              end
            end else if (ramstate == ERROR) begin
              next_state = IDLE;
            end else begin
              wait_inc = 1'b1;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || idle) wait_cnt <= '0;
    else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST)              timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles a grant may wait for ramstate ACCESS.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 iREN  in  1  instruction fetch read request.
REQ-006 iaddr  in  32  fetch address (word_t).
REQ-007 dREN / dWEN  in  1 each  data read / write request.
REQ-008 daddr, dstore  in  32 each  data address and write data.
REQ-009 ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
REQ-010 ramload  in  32  RAM read data.
REQ-011 ramREN, ramWEN  out  1 each  RAM strobes.
REQ-012 ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-013 ihit, dhit  out  1 each  one-cycle completion pulses.
REQ-014 iload, dload  out  32 each  read data returned to the requester.
REQ-015 timeout_err  out  1  sticky watchdog flag.

Function
REQ-016 FSM states: IDLE, GRANT_I, GRANT_D.
REQ-017 IDLE -> GRANT_D when (dREN|dWEN) and (starve_cnt<STARVE_MAX or !iREN).
REQ-018 IDLE -> GRANT_I when iREN and the GRANT_D condition is false.
REQ-019 IDLE with no request: stay IDLE; all RAM strobes low.
REQ-020 GRANT_I drives ramREN=1, ramaddr=iaddr.
REQ-021 GRANT_D drives ramaddr=daddr, ramstore=dstore; ramWEN=dWEN, ramREN=dREN & !dWEN (write wins over read).
REQ-022 In a grant state with ramstate==ACCESS: assert the matching hit combinationally that cycle, route ramload to iload/dload, next state IDLE.
REQ-023 ramstate ERROR in a grant state: no hit; next state IDLE.
REQ-024 Requester drops its request mid-grant: no hit; RAM strobes low that cycle; next state IDLE.
REQ-025 wait_cnt clears on entering a grant and increments each grant cycle without ACCESS; at wait_cnt==TIMEOUT: no hit, next IDLE, timeout_err set until reset.
REQ-026 starve_cnt increments on each IDLE->GRANT_D taken while iREN is high; saturates at STARVE_MAX; clears on IDLE->GRANT_I or when iREN is low in IDLE.
REQ-027 Minimum turnaround: one IDLE cycle between consecutive grants.
REQ-028 iload/dload = ramload when the respective hit is asserted, else 0.

Reset
REQ-029 RST high at a clock edge: state IDLE, starve_cnt=0, wait_cnt=0, timeout_err=0; applies even mid-grant, with no hit issued.
REQ-030 While in reset state: ramREN=ramWEN=0, ramaddr=ramstore=0, ihit=dhit=0, iload=dload=0.

Structure
REQ-031 ramstate_t, word_t and the FSM state enum shall live in cpu_types_pkg.
REQ-032 The priority/starvation decision shall be one sub-module, arb_prio (combinational grant pick plus starve_cnt register).

Verification
REQ-033 iREN=1, iaddr=0x40, ramstate ACCESS on 2nd grant cycle, ramload=0xDEADBEEF -> ihit pulses once, iload=0xDEADBEEF, back to IDLE.
REQ-034 iREN and dWEN held continuously, ACCESS after 1 cycle each grant -> sequence D,D,D,D,I,D..., starve_cnt returns to 0 after the I grant.
REQ-035 dREN=dWEN=1, daddr=0x100 -> ramWEN=1, ramREN=0, dhit on ACCESS.
REQ-036 Grant with ramstate held BUSY -> exit after 15 waiting cycles (wait_cnt==TIMEOUT), no hit, timeout_err=1 until RST.
REQ-037 RST asserted during GRANT_D -> next cycle IDLE, all outputs 0, no dhit.
REQ-038 ramstate ERROR during GRANT_I -> no ihit, IDLE next cycle, timeout_err unchanged.
